// File: rtl/mem.sv
// Single-port synchronous memory with registered read data and an always-ready handshake.
// Define MEM_CLR_ON_RST_EN to clear every location on each reset edge.
module mem #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic                  valid_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  ready_o
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_ready;

  logic w_accept;
  logic w_in_range;
  logic w_wr_en;
  logic w_rd_en;

  assign w_accept   = valid_i & r_ready & ~rst;
  assign w_in_range = {1'b0, addr_i} < LP_DEPTH;
  assign w_wr_en    = w_accept & wr_rd_i & w_in_range;
  assign w_rd_en    = w_accept & ~wr_rd_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Out-of-range reads return zero rather than touching the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_rd_en) begin
      if (w_in_range) begin
        r_rd_data <= r_mem[addr_i];
      end else begin
        r_rd_data <= '0;
      end
    end
  end

`ifdef MEM_CLR_ON_RST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[addr_i] <= wr_data_i;
    end
  end
`else
  // Contents survive reset; w_wr_en already excludes reset edges.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[addr_i] <= wr_data_i;
    end
  end
`endif

  assign rd_data_o = r_rd_data;
  assign ready_o   = r_ready;

endmodule

// File: tb/tb_mem.sv
// Directed scoreboard bench for mem: a 16-deep and a 12-deep
// instance share request fields, with separate valid strobes.
module tb_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wr_data = '0;
  logic [3:0]  addr = '0;
  logic        wr_rd = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid1 = 1'b0;
  logic [15:0] rd0, rd1;
  logic        ready0, ready1;

  int ncmp = 0;
  int nerr = 0;

  logic [15:0] m0 [16];
  logic [15:0] m1 [12];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] last0 = '0;
  logic [15:0] last1 = '0;

  always #5 clk = ~clk;

  mem #(.WIDTH(16), .DEPTH(16), .ADDR_WIDTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .wr_data_i(wr_data), .addr_i(addr),
    .wr_rd_i(wr_rd), .valid_i(valid0),
    .rd_data_o(rd0), .ready_o(ready0)
  );

  mem #(.WIDTH(16), .DEPTH(12), .ADDR_WIDTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .wr_data_i(wr_data), .addr_i(addr),
    .wr_rd_i(wr_rd), .valid_i(valid1),
    .rd_data_o(rd1), .ready_o(ready1)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of request; expected read data is queued when driven
  // and popped once the edge has produced it.
  task automatic step(input string tag, input bit v0, input bit v1,
                      input bit wr, input logic [3:0] a,
                      input logic [15:0] d);
    wr_data = d;
    addr    = a;
    wr_rd   = wr;
    valid0  = v0;
    valid1  = v1;
    if (v0) begin
      if (wr) m0[a] = d;
      else    q0.push_back(m0[a]);
    end
    if (v1) begin
      if (wr) begin
        if (a < 12) m1[a] = d;
      end else begin
        q1.push_back((a < 12) ? m1[a] : 16'h0000);
      end
    end
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    if (q0.size() > 0) last0 = q0.pop_front();
    if (q1.size() > 0) last1 = q1.pop_front();
    check({tag, " rd0"}, rd0, last0);
    check({tag, " rd1"}, rd1, last1);
    check({tag, " rdy0"}, {15'd0, ready0}, 16'd1);
  endtask

  initial begin
    // Hold reset for two edges.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset ready0", {15'd0, ready0}, 16'd0);
      check("reset ready1", {15'd0, ready1}, 16'd0);
      check("reset rd0", rd0, 16'h0000);
    end
`ifdef MEM_CLR_ON_RST_EN
    for (int i = 0; i < 16; i++) m0[i] = '0;
    for (int i = 0; i < 12; i++) m1[i] = '0;
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("release ready0", {15'd0, ready0}, 16'd1);
    check("release ready1", {15'd0, ready1}, 16'd1);
    check("release rd1", rd1, 16'h0000);

    step("wr3", 1, 1, 1, 4'd3, 16'hA5A5);
    step("rd3", 1, 1, 0, 4'd3, 16'h0000);
    check("rd3 value", rd0, 16'hA5A5);

    // Fill both instances; the 12-deep one discards addresses 12..15.
    for (int i = 0; i < 16; i++)
      step("fill", 1, 1, 1, 4'(i), 16'(i * 16'h0101));
    for (int i = 0; i < 16; i++)
      step("readback", 1, 1, 0, 4'(i), 16'hFFFF);
    check("readback last", rd0, 16'h0F0F);

    // Idle requests must not write or disturb rd_data_o.
    step("idle wr5", 0, 0, 1, 4'd5, 16'hFFFF);
    step("idle rd5", 0, 0, 0, 4'd5, 16'hFFFF);
    step("rd5", 1, 1, 0, 4'd5, 16'h0000);
    check("rd5 old", rd0, 16'h0505);

    // Read-after-write in consecutive cycles.
    step("raw wr9", 1, 1, 1, 4'd9, 16'h5A3C);
    step("raw rd9", 1, 1, 0, 4'd9, 16'h0000);
    check("raw value", rd1, 16'h5A3C);

    // Out-of-range write/read on the 12-deep instance.
    step("oor wr13", 0, 1, 1, 4'd13, 16'hBEEF);
    step("oor rd13", 0, 1, 0, 4'd13, 16'h0000);
    check("oor rd13 zero", rd1, 16'h0000);
    for (int i = 0; i < 12; i++)
      step("oor keep", 0, 1, 0, 4'(i), 16'h0000);

    // Reset pulse with a live request: the request must be dropped.
    step("wr7", 1, 1, 1, 4'd7, 16'h1234);
    rst     = 1'b1;
    valid0  = 1'b1;
    valid1  = 1'b1;
    wr_rd   = 1'b1;
    addr    = 4'd7;
    wr_data = 16'h5555;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    last0  = '0;
    last1  = '0;
    check("pulse ready0", {15'd0, ready0}, 16'd0);
    check("pulse rd0", rd0, 16'h0000);
`ifdef MEM_CLR_ON_RST_EN
    for (int i = 0; i < 16; i++) m0[i] = '0;
    for (int i = 0; i < 12; i++) m1[i] = '0;
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("pulse release", {15'd0, ready0}, 16'd1);
    step("rd7", 1, 1, 0, 4'd7, 16'h0000);
`ifdef MEM_CLR_ON_RST_EN
    check("rd7 after rst", rd0, 16'h0000);
`else
    check("rd7 after rst", rd0, 16'h1234);
`endif
    step("rd3 after rst", 1, 1, 0, 4'd3, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
